// File: rtl/axi_sram_slave.sv
// axi_sram_slave
// AXI3 slave answering a 32-bit AXI master from an on-chip word-addressed
// SRAM of 2^MEM_AW x 32 bits. One transaction is in flight at a time; a
// read/write round-robin bit picks the winner when AR and AW arrive together.
//
// Ports
//   clk, resetn                        clock, asynchronous active-low reset
//   ar* (id/addr/len/size/burst/lock/cache/prot/valid), arready
//                                      read address channel (lock/cache/prot/size ignored)
//   rid, rdata, rresp, rlast, rvalid, rready
//                                      read data channel
//   aw* (same set as AR), awready      write address channel
//   wid, wdata, wstrb, wlast, wvalid, wready
//                                      write data channel (wid ignored)
//   bid, bresp, bvalid, bready         write response channel
//
// Build option
//   AXI_SRAM_WRAP_EN  when defined, WRAP bursts with len 1/3/7/15 wrap inside
//                     their (len+1)*4-byte block. When undefined, any WRAP burst
//                     is answered with SLVERR: reads return zero data, writes
//                     are accepted but discarded.
module axi_sram_slave #(
  parameter int MEM_AW = 14,
  parameter int ID_W   = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  input  logic [1:0]      arlock,
  input  logic [3:0]      arcache,
  input  logic [2:0]      arprot,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [7:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  input  logic [1:0]      awlock,
  input  logic [3:0]      awcache,
  input  logic [2:0]      awprot,
  input  logic            awvalid,
  output logic            awready,
  input  logic [ID_W-1:0] wid,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready
);

`ifdef AXI_SRAM_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_SLV   = 2'b10;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            state, state_nxt;
  logic              init_done;
  logic              wr_prio;
  logic [31:0]       mem [2**MEM_AW];
  logic [MEM_AW-1:0] addr_q, addr_nxt;
  logic [7:0]        len_q, beat_q;
  logic [1:0]        burst_q;
  logic              err_q;
  logic              ar_hs, aw_hs, r_hs, w_hs, w_end;
  logic [MEM_AW-1:0] ar_idx, aw_idx;

  // Word index following idx. Wrapping keeps the low log2(len+1) bits
  // cycling while the block base stays put.
  function automatic logic [MEM_AW-1:0] next_idx(input logic [MEM_AW-1:0] idx,
                                                 input logic [7:0] len,
                                                 input logic [1:0] burst);
    logic [MEM_AW-1:0] mask;
    mask = MEM_AW'(len);
    if (WRAP_EN && burst == BURST_WRAP &&
        (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      return (idx & ~mask) | ((idx + 1'b1) & mask);
    return idx + 1'b1;
  endfunction

  // WRAP bursts are refused outright when wrapping is not built in.
  function automatic logic wrap_reject(input logic [1:0] burst);
    return !WRAP_EN && burst == BURST_WRAP;
  endfunction

  assign ar_idx   = araddr[MEM_AW+1:2];
  assign aw_idx   = awaddr[MEM_AW+1:2];
  assign addr_nxt = next_idx(addr_q, len_q, burst_q);
  assign ar_hs    = arvalid && arready;
  assign aw_hs    = awvalid && awready;
  assign r_hs     = rvalid && rready;
  assign w_hs     = wvalid && wready;
  assign w_end    = wlast || (beat_q == len_q);

  logic unused;
  assign unused = ^{arsize, arlock, arcache, arprot, awsize, awlock, awcache, awprot, wid,
                    araddr[31:MEM_AW+2], araddr[1:0], awaddr[31:MEM_AW+2], awaddr[1:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arready   = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    case (state)
      IDLE: begin
        arready = init_done && (!awvalid || !wr_prio);
        awready = init_done && (!arvalid || wr_prio);
        if (arvalid && arready)      state_nxt = RD;
        else if (awvalid && awready) state_nxt = WR;
      end
      RD:   if (rvalid && rready && rlast) state_nxt = IDLE;
      WR: begin
        wready = 1'b1;
        if (wvalid && w_end) state_nxt = RESP;
      end
      RESP: if (bvalid && bready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      init_done <= 1'b0;
      wr_prio   <= 1'b0;
      rvalid    <= 1'b0;
      rlast     <= 1'b0;
      bvalid    <= 1'b0;
      rdata     <= '0;
      rid       <= '0;
      bid       <= '0;
      rresp     <= RESP_OKAY;
      bresp     <= RESP_OKAY;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      init_done <= 1'b1;
      if (ar_hs || aw_hs) wr_prio <= !wr_prio;

      if (ar_hs) begin
        rid     <= arid;
        addr_q  <= ar_idx;
        len_q   <= arlen;
        burst_q <= arburst;
        beat_q  <= '0;
        err_q   <= wrap_reject(arburst);
        rvalid  <= 1'b1;
        rlast   <= (arlen == 8'd0);
        rresp   <= wrap_reject(arburst) ? RESP_SLV : RESP_OKAY;
        rdata   <= wrap_reject(arburst) ? 32'd0 : mem[ar_idx];
      end else if (aw_hs) begin
        bid     <= awid;
        addr_q  <= aw_idx;
        len_q   <= awlen;
        burst_q <= awburst;
        beat_q  <= '0;
        err_q   <= wrap_reject(awburst);
      end

      // rdata only reloads on an accepted beat, so it holds under backpressure.
      if (r_hs) begin
        if (rlast) begin
          rvalid <= 1'b0;
          rlast  <= 1'b0;
        end else begin
          addr_q <= addr_nxt;
          beat_q <= beat_q + 8'd1;
          rlast  <= (beat_q + 8'd1 == len_q);
          rdata  <= err_q ? 32'd0 : mem[addr_nxt];
        end
      end

      // A write ends on wlast or on beat len, whichever comes first; any
      // disagreement between the two is reported but the data stays written.
      if (w_hs) begin
        if (w_end) begin
          bvalid <= 1'b1;
          bresp  <= (err_q || (wlast != (beat_q == len_q))) ? RESP_SLV : RESP_OKAY;
        end else begin
          addr_q <= addr_nxt;
          beat_q <= beat_q + 8'd1;
        end
      end

      if (bvalid && bready) bvalid <= 1'b0;
    end
  end

  // Array has no reset; contents survive resetn.
  always_ff @(posedge clk) begin
    if (w_hs && !err_q) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[addr_q][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Testbench for axi_sram_slave: directed scenarios followed by randomized
// bursts, all checked against a word-array model of the memory.
module tb_axi_sram_slave;
  localparam int MEM_AW = 14;
  localparam int ID_W   = 4;
`ifdef AXI_SRAM_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [ID_W-1:0] arid = '0, awid = '0, wid = '0;
  logic [31:0]     araddr = '0, awaddr = '0, wdata = '0;
  logic [7:0]      arlen = '0, awlen = '0;
  logic [2:0]      arsize = 3'd2, awsize = 3'd2, arprot = '0, awprot = '0;
  logic [1:0]      arburst = 2'd1, awburst = 2'd1, arlock = '0, awlock = '0;
  logic [3:0]      arcache = '0, awcache = '0, wstrb = '0;
  logic            arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic            rready = 1'b0, bready = 1'b0;
  logic            arready, awready, rlast, rvalid, wready, bvalid;
  logic [ID_W-1:0] rid, bid;
  logic [31:0]     rdata;
  logic [1:0]      rresp, bresp;

  always #5 clk = ~clk;

  axi_sram_slave #(.MEM_AW(MEM_AW), .ID_W(ID_W)) dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  logic [31:0] model [0:(1<<MEM_AW)-1];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  int          n_asserts = 0;
  int          n_fail = 0;
  bit          prio = 1'b0;

  initial begin
    #300000;
    $display("FAIL watchdog: observed no end of test by %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word hit by beat i of a burst, computed from byte addresses.
  function automatic int unsigned beat_word(input int unsigned addr, input int unsigned len,
                                            input logic [1:0] burst, input int unsigned i);
    int unsigned a, size, base;
    a = addr & ~32'd3;
    if (WRAP_EN && burst == 2'd2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      size = (len + 1) * 4;
      base = a - (a % size);
      a = base + ((a - base + 4 * i) % size);
    end else begin
      a = a + 4 * i;
    end
    return (a >> 2) % (32'd1 << MEM_AW);
  endfunction

  task automatic do_reset();
    resetn = 1'b0; arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    rready = 1'b0; bready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_arready", arready, 0); check("rst_awready", awready, 0);
    check("rst_rvalid", rvalid, 0);   check("rst_rlast", rlast, 0);
    check("rst_bvalid", bvalid, 0);   check("rst_wready", wready, 0);
    check("rst_rdata", rdata, 0);     check("rst_rid", rid, 0);
    check("rst_bid", bid, 0);         check("rst_rresp", rresp, 0);
    check("rst_bresp", bresp, 0);
    resetn = 1'b1;
    #1;
    check("init_gate_arready", arready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("post_rst_arready", arready, 1);
    check("post_rst_awready", awready, 1);
    prio = 1'b0;
  endtask

  task automatic ar_phase(input int unsigned addr, input int unsigned len,
                          input logic [1:0] burst, input logic [ID_W-1:0] id);
    int cyc = 0;
    arid = id; araddr = addr; arlen = len[7:0]; arburst = burst; arvalid = 1'b1;
    #1;
    while (!arready && cyc < 50) begin @(posedge clk); #1; cyc++; end
    n_asserts++;
    assert (cyc < 50) else begin
      n_fail++; $error("FAIL ar_timeout: observed %0d cycles expected < 50", cyc);
    end
    @(posedge clk); #1;
    arvalid = 1'b0; prio = ~prio;
  endtask

  task automatic aw_phase(input int unsigned addr, input int unsigned len,
                          input logic [1:0] burst, input logic [ID_W-1:0] id);
    int cyc = 0;
    awid = id; awaddr = addr; awlen = len[7:0]; awburst = burst; awvalid = 1'b1;
    #1;
    while (!awready && cyc < 50) begin @(posedge clk); #1; cyc++; end
    n_asserts++;
    assert (cyc < 50) else begin
      n_fail++; $error("FAIL aw_timeout: observed %0d cycles expected < 50", cyc);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; prio = ~prio;
  endtask

  // mode 0: rready always high, 1: toggles 1,0,1,0..., 2: random
  task automatic r_phase(input int unsigned addr, input int unsigned len, input logic [1:0] burst,
                         input logic [ID_W-1:0] id, input int mode);
    int unsigned beat = 0;
    int cyc = 0;
    bit rej, rr;
    logic [31:0] exp_d;
    rej = !WRAP_EN && burst == 2'd2;
    while (beat <= len && cyc < 200) begin
      exp_d = rej ? 32'd0 : model[beat_word(addr, len, burst, beat)];
      check("rvalid", rvalid, 1);
      check("rdata", rdata, exp_d);
      check("rresp", rresp, rej ? 2'd2 : 2'd0);
      check("rlast", rlast, beat == len);
      check("rid", rid, id);
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      rready = rr;
      @(posedge clk); #1;
      cyc++;
      if (rr) beat++;
    end
    n_asserts++;
    assert (cyc < 200) else begin
      n_fail++; $error("FAIL r_timeout: observed %0d cycles expected < 200", cyc);
    end
    rready = 1'b0;
    check("rvalid_end", rvalid, 0);
  endtask

  // last_pos: beat that carries wlast; anything above len means never.
  task automatic w_phase(input int unsigned addr, input int unsigned len, input logic [1:0] burst,
                         input logic [ID_W-1:0] id, input int unsigned last_pos);
    int unsigned end_beat, k, w;
    bit rej, err;
    rej = !WRAP_EN && burst == 2'd2;
    end_beat = (last_pos <= len) ? last_pos : len;
    err = rej || (last_pos != len);
    for (int unsigned i = 0; i <= end_beat; i++) begin
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_pos); wid = id;
      #1;
      check("wready", wready, 1);
      @(posedge clk); #1;
      if (!rej) begin
        w = beat_word(addr, len, burst, i);
        for (int b = 0; b < 4; b++) if (ws[i][b]) model[w][8*b +: 8] = wd[i][8*b +: 8];
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("bvalid", bvalid, 1);
    check("bresp", bresp, err ? 2'd2 : 2'd0);
    check("bid", bid, id);
    check("wready_off", wready, 0);
    k = $urandom_range(0, 2);
    repeat (k) begin @(posedge clk); #1; check("bvalid_hold", bvalid, 1); end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("bvalid_clear", bvalid, 0);
  endtask

  task automatic wr_burst(input int unsigned addr, input int unsigned len, input logic [1:0] burst,
                          input logic [ID_W-1:0] id, input int unsigned last_pos);
    aw_phase(addr, len, burst, id);
    w_phase(addr, len, burst, id, last_pos);
  endtask

  task automatic rd_burst(input int unsigned addr, input int unsigned len, input logic [1:0] burst,
                          input logic [ID_W-1:0] id, input int mode);
    ar_phase(addr, len, burst, id);
    r_phase(addr, len, burst, id, mode);
  endtask

  initial begin
    int unsigned len, addr, lp;
    logic [1:0] burst;
    logic [ID_W-1:0] id;
    int unsigned lset [4];
    lset = '{1, 3, 7, 15};

    do_reset();

    // Single word write then read
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    wr_burst(32'h100, 0, 2'd1, 4'h1, 0);
    rd_burst(32'h100, 0, 2'd1, 4'h2, 0);

    // Four-beat INCR, read back with toggling rready
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    for (int i = 0; i < 4; i++) ws[i] = 4'hF;
    wr_burst(32'h200, 3, 2'd1, 4'h3, 3);
    rd_burst(32'h200, 3, 2'd1, 4'h4, 1);

    // WRAP read len 3 starting at 0x108
    wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
    wr_burst(32'h100, 3, 2'd1, 4'h5, 3);
    rd_burst(32'h108, 3, 2'd2, 4'h6, 0);

    // Byte strobe merge
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    wr_burst(32'h300, 0, 2'd0, 4'h7, 0);
    wd[0] = 32'h0000AB00; ws[0] = 4'h2;
    wr_burst(32'h300, 0, 2'd1, 4'h7, 0);
    rd_burst(32'h300, 0, 2'd1, 4'h8, 0);

    // Arbitration: simultaneous AR/AW, twice
    do_reset();
    wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
    arid = 4'h3; araddr = 32'h200; arlen = 8'd0; arburst = 2'd1;
    awid = 4'h5; awaddr = 32'h400; awlen = 8'd0; awburst = 2'd1;
    arvalid = 1'b1; awvalid = 1'b1;
    #1;
    check("arb1_arready", arready, !prio);
    check("arb1_awready", awready, prio);
    @(posedge clk); #1;
    arvalid = 1'b0; prio = ~prio;
    r_phase(32'h200, 0, 2'd1, 4'h3, 0);
    arid = 4'h6; araddr = 32'h204; arlen = 8'd0; arburst = 2'd1; arvalid = 1'b1;
    #1;
    check("arb2_arready", arready, !prio);
    check("arb2_awready", awready, prio);
    @(posedge clk); #1;
    awvalid = 1'b0; prio = ~prio;
    w_phase(32'h400, 0, 2'd1, 4'h5, 0);
    ar_phase(32'h204, 0, 2'd1, 4'h6);
    r_phase(32'h204, 0, 2'd1, 4'h6, 0);
    rd_burst(32'h400, 0, 2'd1, 4'h1, 0);

    // Early wlast on beat 2 of a len-3 write
    for (int i = 0; i < 4; i++) begin wd[i] = 32'h5000 + i; ws[i] = 4'hF; end
    wr_burst(32'h500, 3, 2'd1, 4'h9, 2);
    rd_burst(32'h500, 2, 2'd1, 4'h9, 0);

    // Randomized region: fill 0x1000..0x10FF, then mixed bursts with aliasing
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      wr_burst(32'h1000 + 64 * k, 15, 2'd1, 4'h0, 15);
    end
    for (int t = 0; t < 40; t++) begin
      len   = ($urandom_range(0, 1) == 1) ? lset[$urandom_range(0, 3)] : $urandom_range(0, 15);
      burst = 2'($urandom_range(0, 2));
      addr  = 32'h1000 + 4 * $urandom_range(0, 63 - len) + ($urandom & 32'hFFFF0000);
      id    = ID_W'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        lp = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 16) : len;
        wr_burst(addr, len, burst, id, lp);
      end else begin
        rd_burst(addr, len, burst, id, int'($urandom_range(0, 2)));
      end
    end

    // Reset during beat 2 of a read
    ar_phase(32'h1000, 7, 2'd1, 4'hA);
    for (int b = 0; b < 2; b++) begin rready = 1'b1; @(posedge clk); #1; end
    rready = 1'b0;
    check("mid_rvalid", rvalid, 1);
    check("mid_rdata", rdata, model[beat_word(32'h1000, 7, 2'd1, 2)]);
    resetn = 1'b0;
    #1;
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_rlast", rlast, 0);
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_arready", arready, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    #1;
    check("rel_arready0", arready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rel_arready2", arready, 1);
    check("rel_rvalid", rvalid, 0);
    prio = 1'b0;
    rd_burst(32'h1000, 3, 2'd1, 4'hB, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
